// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide memory slave with wait states and an I/O window
// Optional write protection of addresses 0..PROT_TOP when MEM_WRPROT_EN is defined.
module mem_responder #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 256,
    parameter int               WAIT_STATES = 0,
    parameter logic [WIDTH-1:0] IO_BASE     = 8'hF0,
    parameter logic [WIDTH-1:0] PROT_TOP    = 8'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] mar,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             memready,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic             err
);

    localparam int               AW         = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] IO_IN_ADDR = IO_BASE + WIDTH'(1);
    localparam logic [3:0]       WAIT_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef MEM_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic [3:0]       cnt, cnt_next;
    logic             accept;
    logic             commit;

    logic             rd_q, wr_q;
    logic [WIDTH-1:0] addr_q, data_q;
    logic [WIDTH-1:0] io_sync1, io_sync2;

    logic [WIDTH-1:0] ram [DEPTH];

    logic             cur_rd, cur_wr;
    logic [WIDTH-1:0] cur_addr, cur_data;
    logic             op_read, op_write, op_bad;
    logic             in_ram, prot_hit;
    logic [AW-1:0]    ram_idx;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (memread || memwrite) begin
                    accept     = 1'b1;
                    cnt_next   = 4'd0;
                    next_state = (WAIT_STATES > 0) ? WAIT : DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    next_state = DONE;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The access takes effect on the edge that enters DONE, whether straight
    // from acceptance (no wait states) or from the last WAIT cycle.
    assign commit = (next_state == DONE);

    // While waiting, the captured request is used so master-side changes are ignored.
    assign cur_rd   = (state == WAIT) ? rd_q   : memread;
    assign cur_wr   = (state == WAIT) ? wr_q   : memwrite;
    assign cur_addr = (state == WAIT) ? addr_q : mar;
    assign cur_data = (state == WAIT) ? data_q : writedata;

    assign op_read  = cur_rd & ~cur_wr;
    assign op_write = cur_wr & ~cur_rd;
    assign op_bad   = cur_rd & cur_wr;

    assign in_ram   = (32'(cur_addr) < 32'(DEPTH)) && (cur_addr < IO_BASE);
    assign ram_idx  = cur_addr[AW-1:0];
    assign prot_hit = PROT_EN && (cur_addr <= PROT_TOP);

    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = ram[ram_idx];
        end else if (cur_addr == IO_BASE) begin
            rdata = io_out;
        end else if (cur_addr == IO_IN_ADDR) begin
            rdata = io_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            memdata  <= '0;
            io_out   <= '0;
            err      <= 1'b0;
            io_sync1 <= '0;
            io_sync2 <= '0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_next;
            io_sync1 <= io_in;
            io_sync2 <= io_sync1;
            if (accept) begin
                rd_q   <= memread;
                wr_q   <= memwrite;
                addr_q <= mar;
                data_q <= writedata;
            end
            if (commit) begin
                if (op_read) begin
                    memdata <= rdata;
                end
                if (op_bad || (op_write && prot_hit)) begin
                    err <= 1'b1;
                end
                if (op_write && !prot_hit && (cur_addr == IO_BASE)) begin
                    io_out <= writedata_sel(cur_data);
                end
            end
        end
    end

    // RAM contents survive reset; a reset cycle suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (reset && commit && op_write && !prot_hit && in_ram) begin
            ram[ram_idx] <= cur_data;
        end
    end

    assign memready = (state == DONE);

    function automatic logic [WIDTH-1:0] writedata_sel(input logic [WIDTH-1:0] d);
        return d;
    endfunction

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (honours MEM_WRPROT_EN)
module tb_mem_responder;

`ifdef MEM_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    localparam logic [7:0] T1 = PROT ? 8'h50 : 8'h10;
    localparam logic [7:0] T2 = PROT ? 8'h60 : 8'h20;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rd_a, wr_a, rdy_a, err_a;
    logic [7:0] mar_a, wd_a, md_a, ioin_a, ioout_a;
    logic       rst_b, rd_b, wr_b, rdy_b, err_b;
    logic [7:0] mar_b, wd_b, md_b, ioin_b, ioout_b;

    mem_responder u_a (
        .clk(clk), .reset(rst_a), .memread(rd_a), .memwrite(wr_a), .mar(mar_a),
        .writedata(wd_a), .memdata(md_a), .memready(rdy_a), .io_in(ioin_a),
        .io_out(ioout_a), .err(err_a)
    );

    mem_responder #(.WAIT_STATES(3)) u_b (
        .clk(clk), .reset(rst_b), .memread(rd_b), .memwrite(wr_b), .mar(mar_b),
        .writedata(wd_b), .memdata(md_b), .memready(rdy_b), .io_in(ioin_b),
        .io_out(ioout_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_md;
        logic       exp_err;
        logic [7:0] exp_io;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rd, input logic wr, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] md,
                                input logic e, input logic [7:0] io);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = d;
        v.exp_md = md; v.exp_err = e; v.exp_io = io;
        tbl.push_back(v);
    endfunction

    // Called at a falling edge; returns at the falling edge of the completion cycle.
    task automatic go_a(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        rd_a = rd; wr_a = wr; mar_a = a; wd_a = d;
        @(posedge clk);
        #1;
        rd_a = 1'b0; wr_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic go_b(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] lat);
        rd_b = rd; wr_b = wr; mar_b = a; wd_b = d;
        @(posedge clk);
        #1;
        rd_b = 1'b0; wr_b = 1'b0;
        lat = 8'd0;
        while (lat < 8'd10) begin
            @(negedge clk);
            lat++;
            if (rdy_b) break;
        end
    endtask

    bit         known [256];
    logic [7:0] mem   [256];
    logic [7:0] m_md, m_io;
    logic       m_err, m_mdk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lat;
        logic       rd, wr;
        logic [7:0] a, d;
        int         k;

        rst_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0; mar_a = '0; wd_a = '0; ioin_a = 8'h81;
        rst_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0; mar_b = '0; wd_b = '0; ioin_b = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_a_memdata", md_a, 8'h00);
        chk("rst_a_memready", rdy_a, 1'b0);
        chk("rst_a_io_out", ioout_a, 8'h00);
        chk("rst_a_err", err_a, 1'b0);
        chk("rst_b_memdata", md_b, 8'h00);
        chk("rst_b_memready", rdy_b, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // back-to-back write then read at zero wait states
        rd_a = 1'b0; wr_a = 1'b1; mar_a = T1; wd_a = 8'hA5;
        @(posedge clk);
        #1;
        rd_a = 1'b1; wr_a = 1'b0;
        @(negedge clk);
        chk("b2b_wr_rdy", rdy_a, 1'b1);
        @(posedge clk);
        #1;
        rd_a = 1'b0;
        @(negedge clk);
        chk("b2b_rd_rdy", rdy_a, 1'b1);
        chk("b2b_rd_data", md_a, 8'hA5);
        @(negedge clk);
        chk("b2b_idle_rdy", rdy_a, 1'b0);

        add(0, 1, 8'h40, 8'h5A, 8'hA5, 0, 8'h00);
        add(1, 0, 8'h40, 8'h00, 8'h5A, 0, 8'h00);
        add(0, 1, 8'hF0, 8'h3C, 8'h5A, 0, 8'h3C);
        add(1, 0, 8'hF0, 8'h00, 8'h3C, 0, 8'h3C);
        add(1, 0, 8'hF1, 8'h00, 8'h81, 0, 8'h3C);
        add(0, 1, 8'hF1, 8'h77, 8'h81, 0, 8'h3C);
        add(1, 0, 8'hF1, 8'h00, 8'h81, 0, 8'h3C);
        add(0, 1, 8'hF7, 8'h11, 8'h81, 0, 8'h3C);
        add(1, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h3C);
        add(0, 1, 8'hEF, 8'h99, 8'h00, 0, 8'h3C);
        add(1, 0, 8'hEF, 8'h00, 8'h99, 0, 8'h3C);
        if (!PROT) add(0, 1, 8'h05, 8'hC7, 8'h99, 0, 8'h3C);
        add(1, 1, 8'h05, 8'h00, 8'h99, 1, 8'h3C);
        if (!PROT) add(1, 0, 8'h05, 8'h00, 8'hC7, 1, 8'h3C);
        add(1, 0, 8'h40, 8'h00, 8'h5A, 1, 8'h3C);
        add(1, 0, T1,    8'h00, 8'hA5, 1, 8'h3C);

        foreach (tbl[i]) begin
            go_a(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_rdy", i), rdy_a, 1'b1);
            chk($sformatf("tbl%0d_memdata", i), md_a, tbl[i].exp_md);
            chk($sformatf("tbl%0d_err", i), err_a, tbl[i].exp_err);
            chk($sformatf("tbl%0d_io_out", i), ioout_a, tbl[i].exp_io);
        end

        // randomized accesses against a behavioural memory model
        foreach (known[i]) known[i] = 1'b0;
        known[8'h40] = 1'b1; mem[8'h40] = 8'h5A;
        known[8'hEF] = 1'b1; mem[8'hEF] = 8'h99;
        known[T1]    = 1'b1; mem[T1]    = 8'hA5;
        if (!PROT) begin known[8'h05] = 1'b1; mem[8'h05] = 8'hC7; end
        m_md = 8'hA5; m_mdk = 1'b1; m_io = 8'h3C; m_err = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (n % 16 == 0) begin
                ioin_a = 8'($urandom);
                repeat (3) @(negedge clk);
            end
            k  = int'($urandom_range(0, 9));
            rd = (k <= 4);
            wr = (k == 0) || (k >= 5);
            a  = ($urandom_range(0, 9) < 6) ? 8'(8'h38 + $urandom_range(0, 15))
                                             : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = 8'(8'hF0 + $urandom_range(0, 3));
            d  = 8'($urandom);
            if (rd && wr) begin
                m_err = 1'b1;
            end else if (wr) begin
                if (PROT && a <= 8'h3F) m_err = 1'b1;
                else if (a < 8'hF0) begin mem[a] = d; known[a] = 1'b1; end
                else if (a == 8'hF0) m_io = d;
            end else begin
                m_mdk = 1'b1;
                if (a < 8'hF0) begin
                    m_mdk = known[a];
                    m_md  = mem[a];
                end else if (a == 8'hF0) m_md = m_io;
                else if (a == 8'hF1) m_md = ioin_a;
                else m_md = 8'h00;
            end
            go_a(rd, wr, a, d);
            chk("rand_rdy", rdy_a, 1'b1);
            chk("rand_err", err_a, m_err);
            chk("rand_io_out", ioout_a, m_io);
            if (m_mdk) chk("rand_memdata", md_a, m_md);
        end

        // three wait states: latency and immunity to mid-wait input changes
        go_b(0, 1, T2, 8'h6B, lat);
        chk("b_wr_latency", lat, 8'd4);
        rd_b = 1'b1; mar_b = T2;
        @(posedge clk);
        #1;
        mar_b = 8'h00; wd_b = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) mar_b = 8'h21;
            if (c < 4) begin
                chk("b_wait_rdy", rdy_b, 1'b0);
            end else begin
                chk("b_done_rdy", rdy_b, 1'b1);
                chk("b_done_data", md_b, 8'h6B);
                rd_b = 1'b0;
            end
        end
        @(negedge clk);
        chk("b_after_rdy", rdy_b, 1'b0);

        // reset in the middle of a pending write
        go_b(0, 1, 8'hF0, 8'h5E, lat);
        go_b(1, 1, 8'h05, 8'h00, lat);
        chk("b_pre_err", err_b, 1'b1);
        chk("b_pre_io", ioout_b, 8'h5E);
        wr_b = 1'b1; mar_b = T2; wd_b = 8'hEE;
        @(posedge clk);
        #1;
        wr_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("abort_memdata", md_b, 8'h00);
        chk("abort_err", err_b, 1'b0);
        chk("abort_io_out", ioout_b, 8'h00);
        for (int c = 0; c < 6; c++) begin
            chk("abort_no_rdy", rdy_b, 1'b0);
            @(negedge clk);
        end
        go_b(1, 0, T2, 8'h00, lat);
        chk("abort_ram_kept", md_b, 8'h6B);

        // write protection boundary
        go_b(0, 1, 8'h3F, 8'hFF, lat);
        chk("prot_3f_rdy", rdy_b, 1'b1);
        chk("prot_3f_err", err_b, PROT);
        if (!PROT) begin
            go_b(1, 0, 8'h3F, 8'h00, lat);
            chk("prot_3f_read", md_b, 8'hFF);
        end
        go_b(0, 1, 8'h40, 8'hFF, lat);
        go_b(0, 1, 8'h41, 8'h12, lat);
        go_b(1, 0, 8'h40, 8'h00, lat);
        chk("prot_40_read", md_b, 8'hFF);
        chk("prot_40_err", err_b, PROT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
